// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the fetch path and the instruction memory model.
package rv32i_pkg;

  localparam int XLEN = 32;

  // Canonical NOP (addi x0, x0, 0); the memory returns this on bubble cycles.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // Byte distance between consecutive 32-bit instructions.
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef logic [XLEN-1:0] word_t;

  // Force a byte address onto a word boundary by clearing the low two bits.
  function automatic word_t alignPc(input word_t pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched instruction and its PC.
// Catches the memory's read data when decode stalls, because the memory
// replaces its output with a NOP on any cycle nobody requests a read.
module fetch_skid_buf
  import rv32i_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  drain,
  input  logic  flush,
  input  word_t d_instr,
  input  word_t d_pc,
  output logic  full,
  output word_t q_instr,
  output word_t q_pc
);

  logic  fullQ, fullD;
  word_t instrQ, instrD;
  word_t pcQ, pcD;

  // Next-state selection: a flush wins over a load, and a load wins over a drain.
  always_comb begin
    fullD  = fullQ;
    instrD = instrQ;
    pcD    = pcQ;
    if (flush) begin
      fullD = 1'b0;
    end else if (load) begin
      fullD  = 1'b1;
      instrD = d_instr;
      pcD    = d_pc;
    end else if (drain) begin
      fullD = 1'b0;
    end
  end

  // Storage for the occupancy flag and the held instruction/PC pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fullQ  <= 1'b0;
      instrQ <= NOP_INSTR;
      pcQ    <= '0;
    end else begin
      fullQ  <= fullD;
      instrQ <= instrD;
      pcQ    <= pcD;
    end
  end

  assign full    = fullQ;
  assign q_instr = instrQ;
  assign q_pc    = pcQ;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues one read per cycle
// to a memory with a one-cycle registered read, and hands instructions to
// decode through a valid/ready handshake. A redirect squashes whatever is in
// flight or held and restarts fetch at the new target.
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000
) (
  input  logic  clk,
  input  logic  rst,
  output word_t imem_addr,
  output logic  imem_en,
  output logic  imem_nop,
  input  word_t imem_instr,
  input  logic  id_ready,
  output logic  if_valid,
  output word_t if_instr,
  output word_t if_pc,
  input  logic  redirect_valid,
  input  word_t redirect_pc
);

  word_t fetchPcQ, fetchPcD;
  logic  inflightQ, inflightD;
  word_t inflightPcQ, inflightPcD;

  logic  skidFull;
  word_t skidInstr;
  word_t skidPc;

  logic  ifValidInt;
  logic  issue;
  logic  skidLoad;
  logic  skidDrain;

  // Handshake and issue decisions plus next-state for the PC and in-flight tracking.
  // Issue is held off during reset so the memory sees no request while rst is high.
  always_comb begin
    ifValidInt  = !rst && !redirect_valid && (skidFull || inflightQ);
    issue       = !rst && !redirect_valid && (!ifValidInt || id_ready);
    skidLoad    = !redirect_valid && !issue && inflightQ && !id_ready && !skidFull;
    skidDrain   = skidFull && id_ready;
    fetchPcD    = fetchPcQ;
    inflightD   = 1'b0;
    inflightPcD = inflightPcQ;
    if (redirect_valid) begin
      fetchPcD = alignPc(redirect_pc);
    end else if (issue) begin
      inflightD   = 1'b1;
      inflightPcD = fetchPcQ;
      fetchPcD    = fetchPcQ + PC_STEP;
    end
  end

  // Fetch PC and in-flight request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetchPcQ    <= RESET_PC;
      inflightQ   <= 1'b0;
      inflightPcQ <= '0;
    end else begin
      fetchPcQ    <= fetchPcD;
      inflightQ   <= inflightD;
      inflightPcQ <= inflightPcD;
    end
  end

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skidLoad),
    .drain   (skidDrain),
    .flush   (redirect_valid),
    .d_instr (imem_instr),
    .d_pc    (inflightPcQ),
    .full    (skidFull),
    .q_instr (skidInstr),
    .q_pc    (skidPc)
  );

  assign imem_addr = fetchPcQ;
  assign imem_en   = issue;
  assign imem_nop  = !issue;
  assign if_valid  = ifValidInt;
  assign if_instr  = skidFull ? skidInstr : imem_instr;
  assign if_pc     = skidFull ? skidPc : inflightPcQ;

  // A held instruction and a fresh in-flight read would mean two candidates for one slot.
  assert property (@(posedge clk) disable iff (rst) !(skidFull && inflightQ));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by a randomized stall/redirect run.
// The reference model tracks only the architectural instruction stream (next expected
// PC, memory contents at that PC, and hold-stability under back-pressure).
module tb_fetch_unit;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imemAddr, imemInstr, ifInstr, ifPc, redirectPc;
  logic        imemEn, imemNop, idReady, ifValid, redirectValid;

  logic [31:0] imemAddr2, imemInstr2, ifInstr2, ifPc2;
  logic        imemEn2, imemNop2, ifValid2;

  logic [31:0] mem [0:255];

  int          compared = 0;
  int          mismatched = 0;
  int          transfers = 0;
  logic [31:0] expPc;
  logic        prevHeld;
  logic [31:0] prevPc, prevInstr;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imemAddr), .imem_en(imemEn), .imem_nop(imemNop), .imem_instr(imemInstr),
    .id_ready(idReady), .if_valid(ifValid), .if_instr(ifInstr), .if_pc(ifPc),
    .redirect_valid(redirectValid), .redirect_pc(redirectPc)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst),
    .imem_addr(imemAddr2), .imem_en(imemEn2), .imem_nop(imemNop2), .imem_instr(imemInstr2),
    .id_ready(1'b1), .if_valid(ifValid2), .if_instr(ifInstr2), .if_pc(ifPc2),
    .redirect_valid(1'b0), .redirect_pc(32'h0)
  );

  always #5 clk = ~clk;

  // Instruction memory with a registered read; bubbles return NOP.
  always @(posedge clk) begin
    imemInstr  <= imemEn ? mem[imemAddr[9:2]] : NOP_INSTR;
    imemInstr2 <= imemEn2 ? (imemAddr2 ^ 32'hA5A5_0000) : NOP_INSTR;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: every accepted instruction must be the next PC in program order.
  task automatic scoreboard();
    checkOutput("nop_is_not_en", {31'b0, imemNop}, {31'b0, !imemEn});
    if (prevHeld && !redirectValid) begin
      checkOutput("hold_valid", {31'b0, ifValid}, 32'd1);
      checkOutput("hold_pc", ifPc, prevPc);
      checkOutput("hold_instr", ifInstr, prevInstr);
    end
    if (ifValid && idReady) begin
      checkOutput("seq_pc", ifPc, expPc);
      checkOutput("seq_instr", ifInstr, mem[expPc[9:2]]);
      expPc = expPc + 32'd4;
      transfers++;
    end
    if (redirectValid) expPc = {redirectPc[31:2], 2'b00};
    prevHeld  = ifValid && !idReady && !redirectValid;
    prevPc    = ifPc;
    prevInstr = ifInstr;
  endtask

  // Advance one cycle, drive inputs shortly after the edge, sample once settled.
  task automatic applyStimulus(input logic rdy, input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #2;
    idReady       = rdy;
    redirectValid = rv;
    redirectPc    = rpc;
    #2;
    scoreboard();
  endtask

  initial begin
    logic [31:0] e;
    rst = 1'b1; idReady = 1'b1; redirectValid = 1'b0; redirectPc = '0;
    prevHeld = 1'b0; prevPc = '0; prevInstr = '0; expPc = '0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;

    // Reset state.
    repeat (2) @(posedge clk);
    #2;
    checkOutput("rst_en", {31'b0, imemEn}, 32'd0);
    checkOutput("rst_nop", {31'b0, imemNop}, 32'd1);
    checkOutput("rst_valid", {31'b0, ifValid}, 32'd0);
    checkOutput("rst_en2", {31'b0, imemEn2}, 32'd0);

    // Release reset: C0 issues the reset PC.
    @(posedge clk);
    #2 rst = 1'b0;
    #2;
    checkOutput("c0_en", {31'b0, imemEn}, 32'd1);
    checkOutput("c0_addr", imemAddr, 32'h0);
    checkOutput("c0_valid", {31'b0, ifValid}, 32'd0);
    checkOutput("c0_addr2", imemAddr2, 32'hFFFF_FFF8);
    expPc = 32'h0;

    // Streaming with id_ready high; second instance wraps past the top of memory.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("stream_valid", {31'b0, ifValid}, 32'd1);
      e = i * 4;
      checkOutput("stream_pc", ifPc, e);
      checkOutput("stream_instr", ifInstr, 32'h11 * (i + 1));
      checkOutput("stream_nop", {31'b0, imemNop}, 32'd0);
      e = 32'hFFFF_FFF8 + 32'd4 * (i + 1);
      if (i < 2) checkOutput("wrap_addr2", imemAddr2, e);
      e = 32'hFFFF_FFF8 + 32'd4 * i;
      if (i < 3) checkOutput("wrap_pc2", ifPc2, e);
    end

    // Three stall cycles with 0x10 in flight: it must be held, no new request.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("stall_valid", {31'b0, ifValid}, 32'd1);
      checkOutput("stall_pc", ifPc, 32'h10);
      checkOutput("stall_instr", ifInstr, mem[4]);
      checkOutput("stall_en", {31'b0, imemEn}, 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("release_pc", ifPc, 32'h10);
    checkOutput("release_addr", imemAddr, 32'h14);
    checkOutput("release_en", {31'b0, imemEn}, 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("after_release_pc", ifPc, 32'h14);
    checkOutput("after_release_valid", {31'b0, ifValid}, 32'd1);

    // Redirect to 0x40: two bubbles, then the target.
    applyStimulus(1'b1, 1'b1, 32'h40);
    checkOutput("redir_r_valid", {31'b0, ifValid}, 32'd0);
    checkOutput("redir_r_en", {31'b0, imemEn}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("redir_r1_valid", {31'b0, ifValid}, 32'd0);
    checkOutput("redir_r1_addr", imemAddr, 32'h40);
    checkOutput("redir_r1_en", {31'b0, imemEn}, 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("redir_r2_pc", ifPc, 32'h40);
    checkOutput("redir_r2_instr", ifInstr, mem[16]);

    // Misaligned redirect while the skid holds 0x44 under back-pressure.
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("skid_fill_pc", ifPc, 32'h44);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("skid_held_pc", ifPc, 32'h44);
    applyStimulus(1'b0, 1'b1, 32'h43);
    checkOutput("skid_redir_valid", {31'b0, ifValid}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("skid_redir_addr", imemAddr, 32'h40);
    checkOutput("skid_redir_valid1", {31'b0, ifValid}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("skid_redir_pc", ifPc, 32'h40);
    applyStimulus(1'b1, 1'b0, 32'h0);

    // Short asynchronous reset pulse mid-stream, no clock edge inside it.
    #1 rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", {31'b0, ifValid}, 32'd0);
    checkOutput("async_rst_en", {31'b0, imemEn}, 32'd0);
    checkOutput("async_rst_nop", {31'b0, imemNop}, 32'd1);
    #1 rst = 1'b0;
    #1;
    checkOutput("post_rst_addr", imemAddr, 32'h0);
    checkOutput("post_rst_en", {31'b0, imemEn}, 32'd1);
    expPc = 32'h0;
    prevHeld = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("post_rst_pc", ifPc, 32'h0);
    checkOutput("post_rst_instr", ifInstr, 32'h11);

    // Randomized back-pressure and redirects against the stream model.
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                    32'($urandom_range(0, 1023)));
    end

    // Bounded liveness: with ready high the stream resumes within two cycles.
    for (int w = 0; w < 3; w++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      if (ifValid) break;
    end
    checkOutput("live_valid", {31'b0, ifValid}, 32'd1);
    checkOutput("transfers_seen", {31'b0, transfers > 100}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch initiator for the RV32I core: owns the fetch PC, drives the request side of the instruction memory, and handles that memory's one-cycle registered read latency. Responses are returned through a valid/ready handshake to decode. A 1-entry skid buffer absorbs decode back-pressure, and redirect squashes wrong-path fetches. It sits between the branch/jump resolution logic and the instruction memory and decode stage.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- imem_addr  output  32  byte address presented to instruction memory (memory indexes address/4)
- imem_en  output  1  read enable (memory `we`); memory samples it at the next rising edge
- imem_nop  output  1  bubble request (memory `nop_in`); always equals !imem_en
- imem_instr  input  32  memory read data; valid the cycle after an imem_en edge
- id_ready  input  1  decode can accept
- if_valid  output  1  if_instr/if_pc hold a valid fetched instruction
- if_instr  output  32  instruction word
- if_pc  output  32  byte address of if_instr
- redirect_valid  input  1  single-cycle taken branch/jump/trap redirect
- redirect_pc  input  32  redirect target; bits [1:0] ignored

## Operation
- State:
  - fetch_pc: next address to request
  - inflight + inflight_pc: a request was issued at the last edge
  - skid_full + skid_instr + skid_pc
- if_valid = !redirect_valid && (skid_full || inflight).
- if_instr = skid_full ? skid_instr : imem_instr. if_pc = skid_full ? skid_pc : inflight_pc.
- Transfer = if_valid && id_ready.
- issue = !redirect_valid && (!if_valid || id_ready). imem_en = issue. imem_addr = fetch_pc.
- On issue:
  - inflight <= 1; inflight_pc <= fetch_pc
  - fetch_pc <= fetch_pc + 4 (mod 2^32; 0xFFFF_FFFC wraps to 0)
- No issue: inflight <= 0. If inflight && !id_ready && !skid_full, then skid <= {imem_instr, inflight_pc} and skid_full <= 1. When not issuing, the memory overwrites its output with NOP, so the capture must happen on the same edge.
- skid_full && id_ready: the skid drains and skid_full <= 0. A new issue happens on the same edge.
- Invariant: skid_full and inflight are never both 1. Assert this in simulation.
- Redirect has priority over everything:
  - fetch_pc <= {redirect_pc[31:2], 2'b00}
  - inflight <= 0; skid_full <= 0
  - no issue; if_valid = 0 that cycle
- No state machine beyond these flags. The effective modes are EMPTY, INFLIGHT, and HELD (skid_full), with transitions as above.

## Timing
- Reset values (asynchronous, apply immediately on rst):
  - fetch_pc = RESET_PC; inflight = 0; skid_full = 0; skid_instr = 32'h0000_0013; skid_pc = 0
  - Combinational outputs during rst: imem_en = 0, imem_nop = 1, if_valid = 0. if_instr follows imem_instr (skid empty) and is not guaranteed to be NOP.
- First cycle after rst falls (C0):
  - C0: imem_en = 1, imem_addr = RESET_PC
  - C1: if_valid = 1, if_pc = RESET_PC
- Steady state with id_ready = 1: one instruction per cycle, PCs consecutive.
- Redirect asserted in cycle R:
  - R+1: request at target
  - R+2: target instruction valid
  - Penalty is two bubbles.
- Back-pressure: if_instr/if_pc stay stable while if_valid && !id_ready. No instruction is lost or duplicated.

## Structure
- Shared package rv32i_pkg:
  - XLEN = 32
  - NOP_INSTR = 32'h0000_0013 (also used by the memory bubble path)
  - PC_STEP = 4
- One sub-module, fetch_skid_buf:
  - Contents: the 1-entry instr+pc holding register with load/clear/drain controls
  - Ports: clk, rst, load, drain, flush, d_instr, d_pc, full, q_instr, q_pc
- The remainder is fetch_unit: PC register, inflight tracking, issue/redirect logic.

## Test plan
- Reset release, RESET_PC = 0, memory words 0..3 = 0x11,0x22,0x33,0x44, id_ready = 1 -> C1..C4 give if_pc 0,4,8,C with matching instrs; imem_nop = 0 throughout.
- id_ready low for 3 cycles with a request in flight -> skid captures; if_instr/if_pc constant; imem_en = 0 during the stall. On release the held instr transfers, then the next PC follows with no gap or duplicate.
- redirect_valid for one cycle with redirect_pc = 0x40 -> if_valid = 0 in R and R+1. R+1 imem_addr = 0x40; R+2 if_pc = 0x40.
- redirect_pc = 0x43 while skid_full and id_ready = 0 -> skid discarded; next request address 0x40.
- Assert rst mid-stream for a partial cycle -> if_valid and imem_en drop immediately. After release the first request is RESET_PC.
- RESET_PC = 0xFFFF_FFF8, id_ready = 1 -> request sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
